// File: rtl/axi_sram_pkg.sv
// Shared AXI encodings, FSM state type and burst legality check for the AXI-to-SRAM responder.
package axi_sram_pkg;

  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] BURST_WRAP  = 2'b10;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  localparam logic [2:0] SIZE_64BIT  = 3'd3;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WR_DATA = 2'd1,
    WR_RESP = 2'd2,
    RD_DATA = 2'd3
  } state_t;

  // A burst we cannot serve still runs to completion, but with SLVERR.
  function automatic logic burst_error(input logic [2:0] size,
                                       input logic [1:0] burst,
                                       input logic [7:0] len);
    logic bad_wrap;
    bad_wrap = (burst == BURST_WRAP) &&
               !(len == 8'd1 || len == 8'd3 || len == 8'd7 || len == 8'd15);
    return (size != SIZE_64BIT) || (burst == 2'b11) || bad_wrap;
  endfunction

endpackage

// File: rtl/axi_burst_addr.sv
// Next SRAM word address for an AXI burst (FIXED / INCR / WRAP), in 64-bit word units.
module axi_burst_addr
  import axi_sram_pkg::*;
#(
  parameter int MEM_AW = 16
) (
  input  logic [MEM_AW-1:0] cur_addr,
  input  logic [7:0]        len,
  input  logic [1:0]        burst,
  output logic [MEM_AW-1:0] next_addr
);

  localparam logic [MEM_AW-1:0] ONE = MEM_AW'(1);

  logic [MEM_AW-1:0] incr_addr;
  logic [MEM_AW-1:0] wrap_mask;

  assign incr_addr = cur_addr + ONE;
  // len is 2^n-1 for a legal WRAP, so it doubles as the in-block offset mask.
  assign wrap_mask = MEM_AW'(len);

  always_comb begin
    next_addr = incr_addr;
    case (burst)
      BURST_FIXED: next_addr = cur_addr;
      BURST_WRAP:  next_addr = (cur_addr & ~wrap_mask) | (incr_addr & wrap_mask);
      default:     next_addr = incr_addr;
    endcase
  end

endmodule

// File: rtl/axi_sram_resp.sv
// AXI4 slave serving one burst at a time from a single-port SRAM with 1-cycle read latency.
module axi_sram_resp
  import axi_sram_pkg::*;
#(
  parameter int ID_WIDTH   = 4,
  parameter int DATA_WIDTH = 64,
  parameter int ADDR_WIDTH = 32,
  parameter int MEM_AW     = 16
) (
  input  logic                    aclk,
  input  logic                    aresetn,
  input  logic                    s_axi_awvalid,
  output logic                    s_axi_awready,
  input  logic [ID_WIDTH-1:0]     s_axi_awid,
  input  logic [ADDR_WIDTH-1:0]   s_axi_awaddr,
  input  logic [7:0]              s_axi_awlen,
  input  logic [2:0]              s_axi_awsize,
  input  logic [1:0]              s_axi_awburst,
  input  logic                    s_axi_wvalid,
  output logic                    s_axi_wready,
  input  logic [DATA_WIDTH-1:0]   s_axi_wdata,
  input  logic [DATA_WIDTH/8-1:0] s_axi_wstrb,
  input  logic                    s_axi_wlast,
  output logic                    s_axi_bvalid,
  input  logic                    s_axi_bready,
  output logic [ID_WIDTH-1:0]     s_axi_bid,
  output logic [1:0]              s_axi_bresp,
  input  logic                    s_axi_arvalid,
  output logic                    s_axi_arready,
  input  logic [ID_WIDTH-1:0]     s_axi_arid,
  input  logic [ADDR_WIDTH-1:0]   s_axi_araddr,
  input  logic [7:0]              s_axi_arlen,
  input  logic [2:0]              s_axi_arsize,
  input  logic [1:0]              s_axi_arburst,
  output logic                    s_axi_rvalid,
  input  logic                    s_axi_rready,
  output logic [ID_WIDTH-1:0]     s_axi_rid,
  output logic [DATA_WIDTH-1:0]   s_axi_rdata,
  output logic [1:0]              s_axi_rresp,
  output logic                    s_axi_rlast,
  output logic                    mem_en,
  output logic                    mem_we,
  output logic [MEM_AW-1:0]       mem_addr,
  output logic [DATA_WIDTH/8-1:0] mem_wstrb,
  output logic [DATA_WIDTH-1:0]   mem_wdata,
  input  logic [DATA_WIDTH-1:0]   mem_rdata
);

  state_t                state;
  logic                  prefer_wr;
  logic                  aw_grant, ar_grant;

  logic [ID_WIDTH-1:0]   wr_id, rd_id;
  logic [7:0]            wr_len, rd_len;
  logic [1:0]            wr_burst, rd_burst;
  logic [MEM_AW-1:0]     wr_addr, rd_addr, wr_next, rd_next;
  logic                  wr_err, wr_bad, rd_err;
  logic [7:0]            wr_cnt;
  logic                  w_hs, w_final, wr_do;

  logic [8:0]            rd_issued;
  logic                  rd_issue, rd_last_issue, rd_room;
  logic                  rd_pending, rd_pending_last;
  logic [DATA_WIDTH-1:0] pend_data;
  logic [1:0]            occupancy;
  logic                  r_pop, r_done;

  logic [DATA_WIDTH-1:0] skid_data [2];
  logic [1:0]            skid_last;
  logic                  skid_rp, skid_wp;
  logic [1:0]            skid_cnt;
  logic                  skid_push, skid_pop;

  logic                  unused_addr_bits;
  assign unused_addr_bits = ^{s_axi_awaddr[ADDR_WIDTH-1:MEM_AW+3], s_axi_awaddr[2:0],
                              s_axi_araddr[ADDR_WIDTH-1:MEM_AW+3], s_axi_araddr[2:0]};

  // Ready is gated by aresetn so nothing is accepted while reset is held.
  assign aw_grant = aresetn && (state == IDLE) && s_axi_awvalid && (prefer_wr || !s_axi_arvalid);
  assign ar_grant = aresetn && (state == IDLE) && s_axi_arvalid && !aw_grant;
  assign s_axi_awready = aw_grant;
  assign s_axi_arready = ar_grant;

  assign s_axi_wready = (state == WR_DATA);
  assign w_hs         = (state == WR_DATA) && s_axi_wvalid;
  assign w_final      = (wr_cnt == wr_len);
  assign wr_do        = w_hs && !wr_err;

  assign s_axi_bvalid = (state == WR_RESP);
  assign s_axi_bid    = wr_id;
  assign s_axi_bresp  = (wr_err || wr_bad) ? RESP_SLVERR : RESP_OKAY;

  // Reads are throttled so everything in flight always fits in the skid buffer.
  assign occupancy     = skid_cnt + {1'b0, rd_pending};
  assign r_pop         = s_axi_rvalid && s_axi_rready;
  assign r_done        = r_pop && s_axi_rlast;
  assign rd_room       = (occupancy - {1'b0, r_pop}) < 2'd2;
  assign rd_issue      = (state == RD_DATA) && (rd_issued != ({1'b0, rd_len} + 9'd1)) && rd_room;
  assign rd_last_issue = (rd_issued[7:0] == rd_len);
  assign pend_data     = rd_err ? '0 : mem_rdata;

  assign s_axi_rvalid = (skid_cnt != 2'd0) || rd_pending;
  assign s_axi_rdata  = (skid_cnt != 2'd0) ? skid_data[skid_rp] : pend_data;
  assign s_axi_rlast  = (skid_cnt != 2'd0) ? skid_last[skid_rp] : rd_pending_last;
  assign s_axi_rid    = rd_id;
  assign s_axi_rresp  = rd_err ? RESP_SLVERR : RESP_OKAY;

  assign skid_push = rd_pending && !((skid_cnt == 2'd0) && r_pop);
  assign skid_pop  = r_pop && (skid_cnt != 2'd0);

  assign mem_en    = wr_do || rd_issue;
  assign mem_we    = wr_do;
  assign mem_addr  = (state == WR_DATA) ? wr_addr : rd_addr;
  assign mem_wstrb = s_axi_wstrb;
  assign mem_wdata = s_axi_wdata;

  axi_burst_addr #(.MEM_AW(MEM_AW)) u_wr_addr (
    .cur_addr (wr_addr),
    .len      (wr_len),
    .burst    (wr_burst),
    .next_addr(wr_next)
  );

  axi_burst_addr #(.MEM_AW(MEM_AW)) u_rd_addr (
    .cur_addr (rd_addr),
    .len      (rd_len),
    .burst    (rd_burst),
    .next_addr(rd_next)
  );

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state     <= IDLE;
      prefer_wr <= 1'b1;
      wr_id     <= '0;
      wr_len    <= '0;
      wr_burst  <= '0;
      wr_addr   <= '0;
      wr_err    <= 1'b0;
      wr_bad    <= 1'b0;
      wr_cnt    <= '0;
      rd_id     <= '0;
      rd_len    <= '0;
      rd_burst  <= '0;
      rd_addr   <= '0;
      rd_err    <= 1'b0;
      rd_issued <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (aw_grant) begin
            wr_id     <= s_axi_awid;
            wr_len    <= s_axi_awlen;
            wr_burst  <= s_axi_awburst;
            wr_addr   <= s_axi_awaddr[MEM_AW+2:3];
            wr_err    <= burst_error(s_axi_awsize, s_axi_awburst, s_axi_awlen);
            wr_bad    <= 1'b0;
            wr_cnt    <= '0;
            prefer_wr <= 1'b0;
            state     <= WR_DATA;
          end else if (ar_grant) begin
            rd_id     <= s_axi_arid;
            rd_len    <= s_axi_arlen;
            rd_burst  <= s_axi_arburst;
            rd_addr   <= s_axi_araddr[MEM_AW+2:3];
            rd_err    <= burst_error(s_axi_arsize, s_axi_arburst, s_axi_arlen);
            rd_issued <= '0;
            prefer_wr <= 1'b1;
            state     <= RD_DATA;
          end
        end
        WR_DATA: begin
          if (w_hs) begin
            wr_addr <= wr_next;
            wr_cnt  <= wr_cnt + 8'd1;
            if (s_axi_wlast != w_final) wr_bad <= 1'b1;
            if (w_final) state <= WR_RESP;
          end
        end
        WR_RESP: begin
          if (s_axi_bready) state <= IDLE;
        end
        RD_DATA: begin
          if (rd_issue) begin
            rd_addr   <= rd_next;
            rd_issued <= rd_issued + 9'd1;
          end
          if (r_done) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // SRAM data lands one cycle after issue; beats the master does not take yet go to the skid buffer.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      rd_pending      <= 1'b0;
      rd_pending_last <= 1'b0;
      skid_data[0]    <= '0;
      skid_data[1]    <= '0;
      skid_last       <= '0;
      skid_rp         <= 1'b0;
      skid_wp         <= 1'b0;
      skid_cnt        <= '0;
    end else begin
      rd_pending      <= rd_issue;
      rd_pending_last <= rd_last_issue;
      if (skid_push) begin
        skid_data[skid_wp] <= pend_data;
        skid_last[skid_wp] <= rd_pending_last;
        skid_wp            <= ~skid_wp;
      end
      if (skid_pop) skid_rp <= ~skid_rp;
      skid_cnt <= skid_cnt + {1'b0, skid_push} - {1'b0, skid_pop};
    end
  end

endmodule

// File: tb/tb_axi_sram_resp.sv
// Directed scoreboard bench for axi_sram_resp: drivers queue expected B/R responses, a negedge monitor checks them.
module tb_axi_sram_resp;
  import axi_sram_pkg::*;

  logic        aclk = 1'b0;
  logic        aresetn = 1'b0;
  logic        s_axi_awvalid, s_axi_awready;
  logic [3:0]  s_axi_awid;
  logic [31:0] s_axi_awaddr;
  logic [7:0]  s_axi_awlen;
  logic [2:0]  s_axi_awsize;
  logic [1:0]  s_axi_awburst;
  logic        s_axi_wvalid, s_axi_wready;
  logic [63:0] s_axi_wdata;
  logic [7:0]  s_axi_wstrb;
  logic        s_axi_wlast;
  logic        s_axi_bvalid, s_axi_bready;
  logic [3:0]  s_axi_bid;
  logic [1:0]  s_axi_bresp;
  logic        s_axi_arvalid, s_axi_arready;
  logic [3:0]  s_axi_arid;
  logic [31:0] s_axi_araddr;
  logic [7:0]  s_axi_arlen;
  logic [2:0]  s_axi_arsize;
  logic [1:0]  s_axi_arburst;
  logic        s_axi_rvalid, s_axi_rready;
  logic [3:0]  s_axi_rid;
  logic [63:0] s_axi_rdata;
  logic [1:0]  s_axi_rresp;
  logic        s_axi_rlast;
  logic        mem_en, mem_we;
  logic [15:0] mem_addr;
  logic [7:0]  mem_wstrb;
  logic [63:0] mem_wdata;
  logic [63:0] mem_rdata;

  axi_sram_resp #(.ID_WIDTH(4), .DATA_WIDTH(64), .ADDR_WIDTH(32), .MEM_AW(16)) dut (
    .aclk(aclk), .aresetn(aresetn),
    .s_axi_awvalid(s_axi_awvalid), .s_axi_awready(s_axi_awready), .s_axi_awid(s_axi_awid),
    .s_axi_awaddr(s_axi_awaddr), .s_axi_awlen(s_axi_awlen), .s_axi_awsize(s_axi_awsize),
    .s_axi_awburst(s_axi_awburst),
    .s_axi_wvalid(s_axi_wvalid), .s_axi_wready(s_axi_wready), .s_axi_wdata(s_axi_wdata),
    .s_axi_wstrb(s_axi_wstrb), .s_axi_wlast(s_axi_wlast),
    .s_axi_bvalid(s_axi_bvalid), .s_axi_bready(s_axi_bready), .s_axi_bid(s_axi_bid),
    .s_axi_bresp(s_axi_bresp),
    .s_axi_arvalid(s_axi_arvalid), .s_axi_arready(s_axi_arready), .s_axi_arid(s_axi_arid),
    .s_axi_araddr(s_axi_araddr), .s_axi_arlen(s_axi_arlen), .s_axi_arsize(s_axi_arsize),
    .s_axi_arburst(s_axi_arburst),
    .s_axi_rvalid(s_axi_rvalid), .s_axi_rready(s_axi_rready), .s_axi_rid(s_axi_rid),
    .s_axi_rdata(s_axi_rdata), .s_axi_rresp(s_axi_rresp), .s_axi_rlast(s_axi_rlast),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wstrb(mem_wstrb),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  always #5 aclk = ~aclk;

  // Behavioural single-port SRAM: read data registered one cycle after mem_en.
  logic [63:0] mem [0:65535];
  always @(posedge aclk) begin
    if (mem_en) begin
      mem_rdata <= mem[mem_addr];
      if (mem_we)
        for (int b = 0; b < 8; b++)
          if (mem_wstrb[b]) mem[mem_addr][b*8 +: 8] = mem_wdata[b*8 +: 8];
    end
  end

  typedef struct packed { logic [3:0] id; logic [1:0] resp; } b_exp_t;
  typedef struct packed { logic [3:0] id; logic [63:0] data; logic [1:0] resp; logic last; } r_exp_t;

  b_exp_t exp_b[$];
  r_exp_t exp_r[$];
  int     grant_log[$];
  int     checks = 0;
  int     errors = 0;
  int     we_count = 0;
  int     r_hs_count = 0;
  logic        stall_prev = 1'b0;
  logic [70:0] stall_snap;

  task automatic check_output(input string name, input logic [127:0] actual, input logic [127:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h expected=%0h", name, actual, expected);
    end
  endtask

  task automatic note_fail(input string name);
    checks++;
    errors++;
    $display("[TB] FAIL %s actual=event expected=none", name);
  endtask

  task automatic push_b(input logic [3:0] id, input logic [1:0] resp);
    exp_b.push_back('{id: id, resp: resp});
  endtask

  task automatic push_r(input logic [3:0] id, input logic [63:0] data, input logic [1:0] resp, input logic last);
    exp_r.push_back('{id: id, data: data, resp: resp, last: last});
  endtask

  // Scoreboard monitor: handshakes seen at negedge complete at the following posedge.
  always @(negedge aclk) begin
    if (aresetn) begin
      if (mem_en && mem_we) we_count++;
      if (s_axi_awvalid && s_axi_awready) grant_log.push_back(1);
      if (s_axi_arvalid && s_axi_arready) grant_log.push_back(2);
      if (stall_prev)
        check_output("r_stall_hold", 128'({s_axi_rvalid, s_axi_rid, s_axi_rdata, s_axi_rresp, s_axi_rlast}),
                     128'({1'b1, stall_snap}));
      stall_prev = s_axi_rvalid && !s_axi_rready;
      stall_snap = {s_axi_rid, s_axi_rdata, s_axi_rresp, s_axi_rlast};
      if (s_axi_bvalid && s_axi_bready) begin
        if (exp_b.size() == 0) note_fail("b_unexpected");
        else begin
          b_exp_t eb;
          eb = exp_b.pop_front();
          check_output("b_resp", 128'({s_axi_bid, s_axi_bresp}), 128'({eb.id, eb.resp}));
        end
      end
      if (s_axi_rvalid && s_axi_rready) begin
        r_hs_count++;
        if (exp_r.size() == 0) note_fail("r_unexpected");
        else begin
          r_exp_t er;
          er = exp_r.pop_front();
          check_output("r_beat", 128'({s_axi_rid, s_axi_rdata, s_axi_rresp, s_axi_rlast}),
                       128'({er.id, er.data, er.resp, er.last}));
        end
      end
    end else begin
      stall_prev = 1'b0;
    end
  end

  task automatic apply_aw(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                          input logic [2:0] size, input logic [1:0] burst);
    logic ok = 1'b0;
    s_axi_awid = id; s_axi_awaddr = addr; s_axi_awlen = len; s_axi_awsize = size; s_axi_awburst = burst;
    s_axi_awvalid = 1'b1;
    for (int i = 0; i < 100 && !ok; i++) begin
      @(negedge aclk); ok = s_axi_awready;
      @(posedge aclk); #1;
    end
    s_axi_awvalid = 1'b0;
    if (!ok) note_fail("aw_timeout");
  endtask

  task automatic apply_w(input logic [63:0] data, input logic [7:0] strb, input logic last);
    logic ok = 1'b0;
    s_axi_wdata = data; s_axi_wstrb = strb; s_axi_wlast = last; s_axi_wvalid = 1'b1;
    for (int i = 0; i < 100 && !ok; i++) begin
      @(negedge aclk); ok = s_axi_wready;
      @(posedge aclk); #1;
    end
    s_axi_wvalid = 1'b0; s_axi_wlast = 1'b0;
    if (!ok) note_fail("w_timeout");
  endtask

  task automatic apply_ar(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                          input logic [2:0] size, input logic [1:0] burst);
    logic ok = 1'b0;
    s_axi_arid = id; s_axi_araddr = addr; s_axi_arlen = len; s_axi_arsize = size; s_axi_arburst = burst;
    s_axi_arvalid = 1'b1;
    for (int i = 0; i < 100 && !ok; i++) begin
      @(negedge aclk); ok = s_axi_arready;
      @(posedge aclk); #1;
    end
    s_axi_arvalid = 1'b0;
    if (!ok) note_fail("ar_timeout");
  endtask

  task automatic wait_idle(input string name);
    logic done = 1'b0;
    for (int i = 0; i < 500 && !done; i++) begin
      @(posedge aclk); #1;
      done = (exp_b.size() == 0) && (exp_r.size() == 0);
    end
    if (!done) note_fail(name);
    @(posedge aclk); #1;
  endtask

  task automatic check_grants(input string name);
    int g0, g1;
    g0 = (grant_log.size() > 0) ? grant_log[0] : 0;
    g1 = (grant_log.size() > 1) ? grant_log[1] : 0;
    check_output(name, 128'({grant_log.size(), g0, g1}), 128'({2, 1, 2}));
    grant_log.delete();
  endtask

  initial begin
    int we0;
    logic saw_rvalid;
    s_axi_awvalid = 0; s_axi_awid = 0; s_axi_awaddr = 0; s_axi_awlen = 0; s_axi_awsize = 0; s_axi_awburst = 0;
    s_axi_wvalid = 0; s_axi_wdata = 0; s_axi_wstrb = 0; s_axi_wlast = 0;
    s_axi_arvalid = 0; s_axi_arid = 0; s_axi_araddr = 0; s_axi_arlen = 0; s_axi_arsize = 0; s_axi_arburst = 0;
    s_axi_bready = 1; s_axi_rready = 1;
    for (int i = 0; i < 4; i++) mem[i] = 64'h10 + 64'(i);
    mem[16'h30] = 64'h3300;
    mem[16'h31] = 64'h3311;

    // Reset: outputs quiet even with requests pending
    repeat (3) @(posedge aclk);
    #1 s_axi_awvalid = 1; s_axi_arvalid = 1;
    #1;
    check_output("rst_awready", 128'(s_axi_awready), 128'(0));
    check_output("rst_arready", 128'(s_axi_arready), 128'(0));
    check_output("rst_wready",  128'(s_axi_wready),  128'(0));
    check_output("rst_bvalid",  128'(s_axi_bvalid),  128'(0));
    check_output("rst_rvalid",  128'(s_axi_rvalid),  128'(0));
    check_output("rst_mem_en",  128'({mem_en, mem_we}), 128'(0));
    s_axi_awvalid = 0; s_axi_arvalid = 0;
    @(posedge aclk); #1 aresetn = 1;
    @(posedge aclk); #1;

    // Simultaneous AW/AR twice: write first each time
    $display("[TB] arbitration");
    grant_log.delete();
    push_b(4'd2, RESP_OKAY);
    push_r(4'd4, 64'h3300, RESP_OKAY, 1'b1);
    fork
      begin apply_aw(4'd2, 32'h100, 8'd0, 3'd3, BURST_INCR); apply_w(64'h2222, 8'hFF, 1'b1); end
      apply_ar(4'd4, 32'h180, 8'd0, 3'd3, BURST_INCR);
    join
    wait_idle("arb1_timeout");
    check_grants("grant_order_1");
    push_b(4'd3, RESP_OKAY);
    push_r(4'd5, 64'h3311, RESP_OKAY, 1'b1);
    fork
      begin apply_aw(4'd3, 32'h108, 8'd0, 3'd3, BURST_INCR); apply_w(64'h2323, 8'hFF, 1'b1); end
      apply_ar(4'd5, 32'h188, 8'd0, 3'd3, BURST_INCR);
    join
    wait_idle("arb2_timeout");
    check_grants("grant_order_2");
    check_output("arb_mem_20", 128'(mem[16'h20]), 128'(64'h2222));

    // INCR write at 0x8000_0040 lands in words 8..11
    $display("[TB] incr write");
    we0 = we_count;
    push_b(4'd5, RESP_OKAY);
    apply_aw(4'd5, 32'h8000_0040, 8'd3, 3'd3, BURST_INCR);
    for (int i = 0; i < 4; i++) apply_w(64'hA0 + 64'(i), 8'hFF, i == 3);
    wait_idle("incr_wr_timeout");
    for (int i = 0; i < 4; i++) check_output("incr_wr_mem", 128'(mem[8 + i]), 128'(64'hA0 + 64'(i)));
    check_output("incr_wr_we_count", 128'(we_count - we0), 128'(4));

    // WRAP read from word 3 of block 0..3, plus first-beat latency
    $display("[TB] wrap read");
    push_r(4'd3, 64'h13, RESP_OKAY, 1'b0);
    push_r(4'd3, 64'h10, RESP_OKAY, 1'b0);
    push_r(4'd3, 64'h11, RESP_OKAY, 1'b0);
    push_r(4'd3, 64'h12, RESP_OKAY, 1'b1);
    apply_ar(4'd3, 32'h18, 8'd3, 3'd3, BURST_WRAP);
    @(negedge aclk);
    check_output("rd_latency_c1", 128'(s_axi_rvalid), 128'(0));
    @(negedge aclk);
    check_output("rd_latency_c2", 128'(s_axi_rvalid), 128'(1));
    wait_idle("wrap_rd_timeout");

    // INCR len=15 read under random backpressure
    $display("[TB] backpressure read");
    for (int i = 0; i < 16; i++) begin
      mem[16'h100 + 16'(i)] = 64'h5500 + 64'(i);
      push_r(4'd6, 64'h5500 + 64'(i), RESP_OKAY, i == 15);
    end
    fork
      apply_ar(4'd6, 32'h800, 8'd15, 3'd3, BURST_INCR);
      for (int i = 0; i < 400 && exp_r.size() != 0; i++) begin
        @(posedge aclk); #1;
        s_axi_rready = 1'($urandom_range(0, 1));
      end
    join
    s_axi_rready = 1;
    wait_idle("bp_rd_timeout");

    // Error bursts: bad size, early wlast, reserved read burst
    $display("[TB] error bursts");
    we0 = we_count;
    push_b(4'd7, RESP_SLVERR);
    apply_aw(4'd7, 32'h200, 8'd1, 3'd2, BURST_INCR);
    apply_w(64'hDEAD, 8'hFF, 1'b0);
    apply_w(64'hBEEF, 8'hFF, 1'b1);
    wait_idle("size_err_timeout");
    check_output("size_err_no_we", 128'(we_count - we0), 128'(0));
    push_b(4'd8, RESP_SLVERR);
    apply_aw(4'd8, 32'h208, 8'd2, 3'd3, BURST_INCR);
    for (int i = 0; i < 3; i++) apply_w(64'hC0 + 64'(i), 8'hFF, i == 0);
    wait_idle("wlast_err_timeout");
    push_r(4'd9, 64'h0, RESP_SLVERR, 1'b0);
    push_r(4'd9, 64'h0, RESP_SLVERR, 1'b1);
    apply_ar(4'd9, 32'h0, 8'd1, 3'd3, 2'b11);
    wait_idle("burst_err_timeout");

    // Reset during beat 5 of a len=7 read
    $display("[TB] reset mid burst");
    for (int i = 0; i < 8; i++) begin
      mem[16'h60 + 16'(i)] = 64'h7700 + 64'(i);
      push_r(4'd10, 64'h7700 + 64'(i), RESP_OKAY, i == 7);
    end
    we0 = r_hs_count;
    apply_ar(4'd10, 32'h300, 8'd7, 3'd3, BURST_INCR);
    for (int i = 0; i < 100 && (r_hs_count - we0) < 4; i++) begin
      @(posedge aclk); #1;
    end
    aresetn = 0;
    #1;
    check_output("reset_rvalid", 128'(s_axi_rvalid), 128'(0));
    exp_r.delete();
    repeat (2) @(posedge aclk);
    #1 aresetn = 1;
    saw_rvalid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge aclk);
      if (s_axi_rvalid) saw_rvalid = 1'b1;
    end
    check_output("reset_no_more_beats", 128'(saw_rvalid), 128'(0));
    @(posedge aclk); #1;
    push_r(4'd11, 64'h7700, RESP_OKAY, 1'b1);
    apply_ar(4'd11, 32'h300, 8'd0, 3'd3, BURST_INCR);
    wait_idle("post_reset_rd_timeout");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog actual=running expected=finished");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule

// File: doc/axi_sram_resp.md
AXI_SRAM_RESP -- requirements
Module: axi_sram_resp

Interface
REQ-001 Parameter ID_WIDTH, default 4, AXI ID width.
REQ-002 Parameter DATA_WIDTH, default 64, AXI and SRAM data width; only 64 is supported.
REQ-003 Parameter ADDR_WIDTH, default 32, AXI address width.
REQ-004 Parameter MEM_AW, default 16, SRAM word-address width (64-bit words).
REQ-005 Port aclk, input, 1 bit: the single clock; all logic is rising-edge.
REQ-006 Port aresetn, input, 1 bit: asynchronous active-low reset.
REQ-007 Ports s_axi_aw{valid,ready,id,addr,len,size,burst}, in/out/in/in/in/in/in, widths 1/1/ID/ADDR/8/3/2: AXI4 write-address channel; other AW sideband inputs are ignored.
REQ-008 Ports s_axi_w{valid,ready,data,strb,last}, in/out/in/in/in, widths 1/1/64/8/1: AXI4 write-data channel.
REQ-009 Ports s_axi_b{valid,ready,id,resp}, out/in/out/out, widths 1/1/ID/2: AXI4 write-response channel.
REQ-010 Ports s_axi_ar{valid,ready,id,addr,len,size,burst}, in/out/in/in/in/in/in, widths 1/1/ID/ADDR/8/3/2: AXI4 read-address channel; other AR sideband inputs are ignored.
REQ-011 Ports s_axi_r{valid,ready,id,data,resp,last}, out/in/out/out/out/out, widths 1/1/ID/64/2/1: AXI4 read-data channel.
REQ-012 Ports mem_en, mem_we, mem_addr, mem_wstrb, mem_wdata, mem_rdata; out/out/out/out/out/in; widths 1/1/MEM_AW/8/64/64: single-port SRAM, read data valid exactly one cycle after mem_en with mem_we low.

Function
REQ-013 The control FSM SHALL have states IDLE, WR_DATA, WR_RESP and RD_DATA; one transaction at a time, no outstanding-transaction overlap.
REQ-014 In IDLE, awready or arready SHALL pulse for one cycle to accept a pending request; if both are valid, the channel not granted last time wins, and write wins first after reset.
REQ-015 The SRAM word address SHALL be axaddr[MEM_AW+2:3]; higher address bits are ignored, so the space aliases.
REQ-016 Burst addressing: FIXED holds the address; INCR adds 1 word per beat and wraps modulo 2^MEM_AW; WRAP wraps within a (len+1)-word aligned block.
REQ-017 Any of the following SHALL mark the transaction SLVERR: size != 3, burst == 3, or WRAP with len not in {1,3,7,15}.
REQ-018 An SLVERR transaction SHALL still complete all len+1 beats, with writes suppressed (mem_we low) and read data 0.
REQ-019 WR_DATA: wready high. Each W handshake drives a write the same cycle (mem_en, mem_we, mem_wstrb=wstrb, mem_wdata=wdata). After beat len+1, go to WR_RESP.
REQ-020 If wlast is not asserted exactly on beat len+1, bresp SHALL be SLVERR; beat count from awlen governs termination.
REQ-021 WR_RESP: bvalid high with the latched awid and response, held stable until bready, then go to IDLE.
REQ-022 RD_DATA: issue SRAM reads and return len+1 beats with rid = latched arid, rresp, and rlast on the final beat only, then go to IDLE after the last R handshake.
REQ-023 With rready held high, read throughput SHALL be one beat per cycle after a 2-cycle first-beat latency from the AR handshake.
REQ-024 Under arbitrary rready backpressure, no beat SHALL be lost, duplicated or reordered, and R outputs SHALL be stable while rvalid && !rready (2-entry skid buffer permitted).
REQ-025 mem_en SHALL be low whenever no access is issued; reads and writes never issue in the same cycle.

Reset
REQ-026 On aresetn low, asynchronously: all ready/valid outputs 0, mem_en and mem_we 0, FSM to IDLE, beat counters 0, arbitration pointer to write.
REQ-027 Reset mid-burst SHALL abandon the transaction with no response issued; the block resumes in IDLE one cycle after aresetn rises.

Structure
REQ-028 Package axi_sram_pkg SHALL hold the burst encodings (FIXED/INCR/WRAP), response codes (OKAY/SLVERR), the supported size constant (3) and the FSM state enum.
REQ-029 Sub-module axi_burst_addr SHALL compute the next word address from current address, len and burst, and SHALL be instantiated for both the read and write paths.

Verification
REQ-030 INCR write at 0x8000_0040, len=3, data 0xA0..0xA3, strb 0xFF -> words 8..11 written, bresp=OKAY, bid echoed.
REQ-031 WRAP read at 0x18, len=3 over words 0..3 = 0x10..0x13 -> returns 0x13,0x10,0x11,0x12, rlast on 4th beat, rresp=OKAY.
REQ-032 INCR read, len=15, with rready toggling pseudo-randomly -> 16 beats in order, values stable while stalled.
REQ-033 AW and AR valid in the same cycle twice in succession -> write granted first, read second.
REQ-034 Write with awsize=2, len=1 -> 2 W beats accepted, no mem_we, bresp=SLVERR; write with wlast on beat 1 of len=2 -> bresp=SLVERR.
REQ-035 aresetn asserted during beat 5 of a len=7 read -> rvalid=0 immediately, no further beats, and a new AR is accepted afterwards.
